// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   branch_mode_t : 3-bit branch-mode code carried on BRANCH
//   BR_*          : branch-mode encodings (BR_CLR doubles as the taken-counter clear code)
//   INSTR_BYTES   : byte size of one instruction word
package pc_pkg;

   typedef logic [2:0] branch_mode_t;

   localparam branch_mode_t BR_NONE = 3'b000;
   localparam branch_mode_t BR_EQ   = 3'b001;
   localparam branch_mode_t BR_NE   = 3'b010;
   localparam branch_mode_t BR_LT   = 3'b011;
   localparam branch_mode_t BR_GE   = 3'b100;
   localparam branch_mode_t BR_CLR  = 3'b111;

   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/return_stack.sv
// return_stack: circular LIFO of return addresses.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : push push_data_i (ignored when pop_i is also high)
//   pop_i          : pop the top entry (no effect when empty)
//   top_o          : most recently pushed live entry
//   empty_o/full_o : 0 / RAS_DEPTH live entries
//   underflow_o    : pop requested while empty (combinational)
// A push while full overwrites the oldest entry; the count saturates.
module return_stack #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              underflow_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_prev;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_pop, do_push;

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == CNT_W'(RAS_DEPTH));
   // ptr_q is the next write slot, so the top lives one below it
   assign ptr_prev    = ptr_q - PTR_W'(1);
   assign top_o       = mem_q[ptr_prev];
   assign do_pop      = pop_i & ~empty_o;
   assign do_push     = push_i & ~pop_i;
   assign underflow_o = pop_i & empty_o & rst_ni;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (do_pop) begin
         ptr_d = ptr_prev;
         cnt_d = cnt_q - CNT_W'(1);
      end else if (do_push) begin
         ptr_d = ptr_q + PTR_W'(1);
         if (!full_o) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage needs no reset: entries are only visible through cnt_q
   always_ff @(posedge clk_i) begin
      if (do_push && rst_ni) mem_q[ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: program counter with next-PC mux, conditional branches and a
// return-address stack for CALL/RET.
//   CLK, RESET      : clock, asynchronous active-low reset
//   STALL           : hold PC and stack this cycle
//   BRANCH_ADDRESS  : signed word offset; BRANCH: branch mode (pc_pkg)
//   JUMP/CALL/RET   : relative jump / relative call / return
//   ZERO, NEG       : ALU flags
//   PC_OUT          : registered PC; PC_NEXT: combinational next PC
//   RAS_EMPTY/FULL  : stack occupancy; RAS_UNDERFLOW: RET while empty
// Optional macro PC_TAKEN_CNT_EN adds TAKEN_CNT, a saturating 16-bit count of
// redirected (non-sequential) cycles; cleared by CALL+RET with BRANCH=111.
module pc_unit_ras
   import pc_pkg::*;
#(
   parameter int unsigned      ADDR_W       = 32,
   parameter int unsigned      OFFSET_W     = 8,
   parameter int unsigned      RAS_DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                STALL,
   input  logic [OFFSET_W-1:0] BRANCH_ADDRESS,
   input  logic [2:0]          BRANCH,
   input  logic                JUMP,
   input  logic                CALL,
   input  logic                RET,
   input  logic                ZERO,
   input  logic                NEG,
   output logic [ADDR_W-1:0]   PC_OUT,
   output logic [ADDR_W-1:0]   PC_NEXT,
   output logic                RAS_EMPTY,
   output logic                RAS_FULL,
   output logic                RAS_UNDERFLOW
`ifdef PC_TAKEN_CNT_EN
   ,output logic [15:0]        TAKEN_CNT
`endif
);

   localparam int unsigned PAD_W = ADDR_W - OFFSET_W;

   logic [ADDR_W-1:0] pc_q, seq_addr, tgt_addr, offset_bytes, ras_top;
   logic              branch_taken, ras_push, ras_pop;

   assign seq_addr     = pc_q + ADDR_W'(INSTR_BYTES);
   assign offset_bytes = {{PAD_W{BRANCH_ADDRESS[OFFSET_W-1]}}, BRANCH_ADDRESS}
                         << $clog2(INSTR_BYTES);
   assign tgt_addr     = seq_addr + offset_bytes;

   always_comb begin
      branch_taken = 1'b0;
      case (branch_mode_t'(BRANCH))
         BR_EQ:   branch_taken = ZERO;
         BR_NE:   branch_taken = ~ZERO;
         BR_LT:   branch_taken = NEG;
         BR_GE:   branch_taken = ~NEG;
         default: branch_taken = 1'b0;
      endcase
   end

   always_comb begin
      PC_NEXT = seq_addr;
      if (RET) begin
         if (!RAS_EMPTY) PC_NEXT = ras_top;
      end else if (CALL || JUMP || branch_taken) begin
         PC_NEXT = tgt_addr;
      end
   end

   // RET beats CALL: a simultaneous CALL neither pushes nor redirects
   assign ras_pop  = RET & ~STALL;
   assign ras_push = CALL & ~RET & ~STALL;

   return_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_return_stack (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .push_data_i (seq_addr),
      .top_o       (ras_top),
      .empty_o     (RAS_EMPTY),
      .full_o      (RAS_FULL),
      .underflow_o (RAS_UNDERFLOW)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)      pc_q <= RESET_VECTOR;
      else if (!STALL) pc_q <= PC_NEXT;
   end

   assign PC_OUT = pc_q;

`ifdef PC_TAKEN_CNT_EN
   logic [15:0] taken_cnt_q;
   logic        taken_evt, taken_clr;

   assign taken_evt = ~STALL & ((PC_NEXT != seq_addr) | (RET & ~RAS_EMPTY));
   assign taken_clr = CALL & RET & (branch_mode_t'(BRANCH) == BR_CLR);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                                taken_cnt_q <= '0;
      else if (taken_clr)                        taken_cnt_q <= '0;
      else if (taken_evt && taken_cnt_q != '1)   taken_cnt_q <= taken_cnt_q + 16'd1;
   end

   assign TAKEN_CNT = taken_cnt_q;
`endif

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised successor to the single-cycle program counter and PC-incrementer pair; merges both into one block.
- Adds the following:
  - configurable address and offset widths;
  - configurable reset vector;
  - pipeline stall;
  - signed branch compare modes;
  - a circular return-address stack (RAS) serving CALL/RET.
- Sits between the control unit/ALU flags and instruction memory; drives the fetch address.

Parameters:
ADDR_W, 32, width of PC and all addresses
OFFSET_W, 8, width of the signed word offset carried in the instruction
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_VECTOR, 32'h0000_0000, PC value on reset

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset (asserted when 0)
STALL  in  1  hold PC and RAS this cycle
BRANCH_ADDRESS  in  OFFSET_W  signed word offset
BRANCH  in  3  branch mode (see Behaviour)
JUMP  in  1  unconditional relative jump
CALL  in  1  relative jump, push return address
RET  in  1  jump to popped return address
ZERO  in  1  ALU zero flag
NEG  in  1  ALU sign flag (result < 0)
PC_OUT  out  ADDR_W  current PC (registered)
PC_NEXT  out  ADDR_W  combinational next-PC
RAS_EMPTY  out  1  stack holds 0 entries
RAS_FULL  out  1  stack holds RAS_DEPTH entries
RAS_UNDERFLOW  out  1  one-cycle pulse: RET issued while empty

Behaviour:
- Reset (RESET=0, async):
  - PC_OUT=RESET_VECTOR.
  - RAS count=0, pointer=0, so RAS_EMPTY=1 and RAS_FULL=0.
  - RAS_UNDERFLOW=0.
  - Entry contents are don't-care.
- Address arithmetic:
  - SEQ = PC_OUT + 4.
  - TGT = SEQ + (sign-extend BRANCH_ADDRESS to ADDR_W) shifted left by 2.
  - All sums are modulo 2^ADDR_W; wrap-around is silent.
- BRANCH encodings: 000 none, 001 BEQ (ZERO), 010 BNE (!ZERO), 011 BLT (NEG), 100 BGE (!NEG). Codes 101–111 behave as none.
- Next-PC priority:
  1. RET: if not empty, top of stack; if empty, SEQ and RAS_UNDERFLOW pulses.
  2. CALL: TGT.
  3. JUMP: TGT.
  4. Branch condition true: TGT.
  5. Otherwise: SEQ.
- PC_NEXT is combinational and valid in the same cycle as its inputs. PC_OUT takes PC_NEXT at the next rising edge, giving 1-cycle latency.
- STALL=1:
  - PC_OUT holds; no push or pop.
  - RAS_UNDERFLOW is suppressed.
  - PC_NEXT still reflects the computed value.
- CALL (not stalled):
  - Push SEQ at the write pointer; pointer increments mod RAS_DEPTH.
  - count = min(count+1, RAS_DEPTH).
  - When full, the push overwrites the oldest entry (circular) and RAS_FULL stays 1.
- RET (not stalled, not empty): pointer decrements mod RAS_DEPTH; count decrements.
- CALL and RET in the same cycle: RET wins. Pop only; CALL is ignored entirely.
- After RAS_DEPTH+k calls, only the newest RAS_DEPTH returns are valid. Further RETs underflow.
- Reset mid-operation returns everything to reset values immediately. No pending push completes.

Optional Feature:
- Macro: PC_TAKEN_CNT_EN.
- When defined:
  - Adds output TAKEN_CNT (16 bits) counting non-stalled cycles where PC_NEXT != SEQ, or where a RET popped a valid entry.
  - The counter saturates at 16'hFFFF.
  - It resets to 0 on RESET and clears synchronously when CALL and RET are both high with BRANCH=111.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package pc_pkg holds:
  - BRANCH encoding constants (BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE);
  - the INSTR_BYTES=4 constant;
  - the 3-bit branch-mode typedef.
- One sub-module, return_stack. It is a circular LIFO parametrised by ADDR_W and RAS_DEPTH, with push, pop, top, empty, full and underflow.
- The top level keeps the PC register and next-PC mux.

Test Plan:
- Reset with RESET_VECTOR=32'h100, then release; no control inputs for 3 cycles -> PC_OUT 100,104,108,10C; RAS_EMPTY=1.
- PC=0x20, BRANCH=001, ZERO=1, BRANCH_ADDRESS=8'hFE -> PC_NEXT=0x1C, PC_OUT=0x1C next edge. Repeat with ZERO=0 -> 0x24.
- BLT with NEG=1, offset 8'h03, PC=0x40 -> 0x50. STALL=1 held for 2 cycles -> PC_OUT stays 0x40.
- CALL at PC 0x10, 0x30, 0x50, 0x70, 0x90 (depth 4, offset 0) -> RAS_FULL after 4. Five RETs -> 0x94,0x74,0x54,0x34, then SEQ with a RAS_UNDERFLOW pulse.
- CALL and RET in the same cycle with one entry (0x14) -> PC_NEXT=0x14, stack empty, nothing pushed.
- Assert RESET=0 asynchronously mid-cycle after 2 CALLs -> PC_OUT=RESET_VECTOR immediately, RAS_EMPTY=1. With PC_TAKEN_CNT_EN defined, TAKEN_CNT=0.
